seq_divider: RTL and testbench

Multi-cycle 32-bit restoring divider that produces the packed 64-bit divide result and a one-cycle write strobe for the Hi/Lo result register in the pipeline CPU's EX stage. It serves MIPS DIV and DIVU. The block accepts operands on a start pulse and computes one quotient bit per cycle. It holds the result stable until the next operation completes.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 40 ++++
 rtl/seq_divider.sv | 179 +++++++++++++++++
 tb/tb_seq_divider.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider slice.
//   divState_t  : controller states (IDLE, CALC, FIX, DONE)
//   DIV_WIDTH   : native operand width of the CPU datapath
//   DIV0_QUOT   : quotient reported when the divisor is zero
//   QUOT_LSB    : bit offset of the quotient (Lo) inside the packed result
//   REM_LSB     : bit offset of the remainder (Hi) inside the packed result
// -----------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } divState_t;

   localparam int                   DIV_WIDTH = 32;
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam int                   QUOT_LSB  = 32;
   localparam int                   REM_LSB   = 0;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One iteration of an unsigned restoring divider (purely combinational).
// The {rem, quo} pair is shifted left by one; the divisor magnitude is then
// trial-subtracted from the widened partial remainder. A non-negative trial
// is kept and yields a quotient bit of 1, otherwise the shifted remainder is
// restored and the quotient bit is 0.
// Ports:
//   i_rem        : current partial remainder
//   i_quo        : current quotient / remaining dividend bits
//   i_divisorMag : divisor magnitude
//   o_rem        : partial remainder after this step
//   o_quo        : quotient register after this step
// -----------------------------------------------------------------------------
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisorMag,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   // The shifted remainder can reach 2*divisor-1, so the trial needs one
   // extra bit; its MSB is then the borrow/sign of the subtraction.
   logic [WIDTH:0] w_shiftedRem;
   logic [WIDTH:0] w_trial;
   logic           w_trialNeg;

   assign w_shiftedRem = {i_rem, i_quo[WIDTH-1]};
   assign w_trial      = w_shiftedRem - {1'b0, i_divisorMag};
   assign w_trialNeg   = w_trial[WIDTH];

   assign o_rem = w_trialNeg ? w_shiftedRem[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign o_quo = {i_quo[WIDTH-2:0], ~w_trialNeg};

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider for MIPS DIV / DIVU in the EX stage.
// One quotient bit per cycle; fixed latency of 33 clock edges from the
// accepted start to the done strobe, divide-by-zero included.
// Ports:
//   clk         : clock, everything on posedge
//   reset       : synchronous active-high reset, aborts any operation
//   start       : operation request, only looked at while idle
//   is_signed   : 1 = DIV (two's complement), 0 = DIVU
//   dividend    : numerator, sampled with start
//   divisor     : denominator, sampled with start
//   busy        : high from the cycle after start until the return to idle
//   done        : one-cycle strobe, Hi/Lo register write enable
//   div_ans     : {quotient (Lo), remainder (Hi)}, held between operations
//   div_by_zero : qualifies done; set when the divisor was zero
// -----------------------------------------------------------------------------
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int ITERS = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] div_ans,
   output logic               div_by_zero
);

   localparam int               CNT_W    = $clog2(ITERS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   divState_t r_state;
   divState_t w_nextState;

   logic [CNT_W-1:0]   r_counter;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_divisorMag;
   logic [WIDTH-1:0]   r_dividendRaw;
   logic               r_signQ;
   logic               r_signR;
   logic               r_div0;
   logic               r_busy;
   logic               r_done;
   logic               r_divByZero;
   logic [2*WIDTH-1:0] r_divAns;

   logic               w_accept;
   logic [WIDTH-1:0]   w_dividendMag;
   logic [WIDTH-1:0]   w_divisorMag;
   logic [WIDTH-1:0]   w_stepRem;
   logic [WIDTH-1:0]   w_stepQuo;
   logic [WIDTH-1:0]   w_quotFinal;
   logic [WIDTH-1:0]   w_remFinal;
   logic [2*WIDTH-1:0] w_result;

   // Operands are converted to magnitudes at issue time so the iterative
   // core only ever does unsigned division. Negating 0x80000000 gives
   // 0x80000000 again, which read as unsigned is exactly 2^31.
   assign w_accept      = (r_state == IDLE) && start;
   assign w_dividendMag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign w_divisorMag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem        (r_rem),
      .i_quo        (r_quo),
      .i_divisorMag (r_divisorMag),
      .o_rem        (w_stepRem),
      .o_quo        (w_stepQuo)
   );

   // State register for the controller.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: one pass through CALC per quotient bit, then a
   // single fix-up cycle and a single strobe cycle before going idle again.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE:    if (start) w_nextState = CALC;
         CALC:    if (r_counter == LAST_CNT) w_nextState = FIX;
         FIX:     w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Sign fix-up of the unsigned result. The quotient is negative when the
   // operand signs differ; the remainder always takes the dividend's sign.
   // A zero divisor bypasses this and reports all-ones / raw dividend.
   always_comb begin
      w_quotFinal = r_signQ ? -r_quo : r_quo;
      w_remFinal  = r_signR ? -r_rem : r_rem;
      w_result    = '0;
      if (r_div0) begin
         w_result[QUOT_LSB +: WIDTH] = DIV0_QUOT;
         w_result[REM_LSB  +: WIDTH] = r_dividendRaw;
      end else begin
         w_result[QUOT_LSB +: WIDTH] = w_quotFinal;
         w_result[REM_LSB  +: WIDTH] = w_remFinal;
      end
   end

   // Datapath and output registers. Operands are captured only on an
   // accepted start, so a start raised mid-operation cannot disturb the
   // calculation. The result register is written only in FIX, which keeps
   // the previous answer visible until the next operation finishes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_counter     <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_divisorMag  <= '0;
         r_dividendRaw <= '0;
         r_signQ       <= 1'b0;
         r_signR       <= 1'b0;
         r_div0        <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_divByZero   <= 1'b0;
         r_divAns      <= '0;
      end else begin
         r_busy <= (w_nextState != IDLE);
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_signQ       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_signR       <= is_signed & dividend[WIDTH-1];
                  r_quo         <= w_dividendMag;
                  r_divisorMag  <= w_divisorMag;
                  r_dividendRaw <= dividend;
                  r_div0        <= (divisor == '0);
                  r_rem         <= '0;
                  r_counter     <= '0;
               end
            end
            CALC: begin
               r_rem     <= w_stepRem;
               r_quo     <= w_stepQuo;
               r_counter <= r_counter + 1'b1;
            end
            FIX: begin
               r_divAns    <= w_result;
               r_done      <= 1'b1;
               r_divByZero <= r_div0;
            end
            DONE: begin
               r_done      <= 1'b0;
               r_divByZero <= 1'b0;
            end
            default: begin
               r_done      <= 1'b0;
               r_divByZero <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_ans     = r_divAns;
   assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed testbench for seq_divider. Every operation is driven on a falling
// edge and sampled on falling edges, so outputs are observed half a cycle
// after the rising edge that produced them. Expected results are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [63:0] div_ans;
   logic        div_by_zero;

   int          vecCount  = 0;
   int          missCount = 0;
   logic [63:0] prevAns   = 64'h0;

   always #5 clk = ~clk;

   seq_divider #(
      .WIDTH (32),
      .ITERS (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_ans     (div_ans),
      .div_by_zero (div_by_zero)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Called on a falling edge: presents operands with start high across the
   // next rising edge (E0), then drops start on the following falling edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic s);
      dividend  = a;
      divisor   = b;
      is_signed = s;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Full operation with timing checks. If pulseAt is non-zero, a competing
   // start (50 / 5 unsigned) is raised across edge E<pulseAt>.
   task automatic runOp(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic s,
                        input logic [63:0] expAns, input logic expDz,
                        input int pulseAt);
      logic earlyDone;
      earlyDone = 1'b0;
      applyStimulus(a, b, s);
      checkOutput({tag, ".busyE1"}, {63'b0, busy}, 64'd1);
      for (int k = 1; k <= 32; k++) begin
         if (k == pulseAt) begin
            dividend  = 32'd50;
            divisor   = 32'd5;
            is_signed = 1'b0;
            start     = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (done) earlyDone = 1'b1;
      end
      checkOutput({tag, ".noEarlyDone"}, {63'b0, earlyDone}, 64'd0);
      checkOutput({tag, ".ansHeldE32"}, div_ans, prevAns);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, ".doneE33"}, {63'b0, done}, 64'd1);
      checkOutput({tag, ".busyE33"}, {63'b0, busy}, 64'd1);
      checkOutput({tag, ".ans"}, div_ans, expAns);
      checkOutput({tag, ".dz"}, {63'b0, div_by_zero}, {63'b0, expDz});
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, ".doneE34"}, {63'b0, done}, 64'd0);
      checkOutput({tag, ".busyE34"}, {63'b0, busy}, 64'd0);
      checkOutput({tag, ".dzE34"}, {63'b0, div_by_zero}, 64'd0);
      checkOutput({tag, ".ansHeld"}, div_ans, expAns);
      prevAns = expAns;
   endtask

   initial begin
      logic sawDone;
      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst.busy", {63'b0, busy}, 64'd0);
      checkOutput("rst.done", {63'b0, done}, 64'd0);
      checkOutput("rst.dz", {63'b0, div_by_zero}, 64'd0);
      checkOutput("rst.ans", div_ans, 64'h0);
      reset = 1'b0;
      @(negedge clk);

      runOp("divu100_7",  32'd100,       32'd7,         1'b0, 64'h0000000E_00000002, 1'b0, 0);
      runOp("divNeg7_2",  32'hFFFFFFF9,  32'h00000002,  1'b1, 64'hFFFFFFFD_FFFFFFFF, 1'b0, 0);
      runOp("div7_neg2",  32'h00000007,  32'hFFFFFFFE,  1'b1, 64'hFFFFFFFD_00000001, 1'b0, 0);
      runOp("divuBig_2",  32'hFFFFFFF9,  32'h00000002,  1'b0, 64'h7FFFFFFC_00000001, 1'b0, 0);
      runOp("divOvf",     32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h80000000_00000000, 1'b0, 0);
      runOp("divuMax_1",  32'hFFFFFFFF,  32'h00000001,  1'b0, 64'hFFFFFFFF_00000000, 1'b0, 0);
      runOp("divuMaxMax", 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'h00000001_00000000, 1'b0, 0);
      runOp("divuSmall",  32'hFFFFFFFE,  32'hFFFFFFFF,  1'b0, 64'h00000000_FFFFFFFE, 1'b0, 0);
      runOp("divNegNeg",  32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 64'h0000000E_FFFFFFFE, 1'b0, 0);
      runOp("divuZero",   32'h12345678,  32'h00000000,  1'b0, 64'hFFFFFFFF_12345678, 1'b1, 0);
      runOp("divZeroNeg", 32'h87654321,  32'h00000000,  1'b1, 64'hFFFFFFFF_87654321, 1'b1, 0);

      // A start raised mid-operation must be ignored; the next issue right
      // after returning to idle must then run normally.
      runOp("ignStart",   32'd100,       32'd7,         1'b0, 64'h0000000E_00000002, 1'b0, 10);
      runOp("b2b50_5",    32'd50,        32'd5,         1'b0, 64'h0000000A_00000000, 1'b0, 0);

      // Reset in the middle of a calculation aborts it.
      applyStimulus(32'd100, 32'd7, 1'b0);
      repeat (13) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort.busy", {63'b0, busy}, 64'd0);
      checkOutput("abort.done", {63'b0, done}, 64'd0);
      checkOutput("abort.ans", div_ans, 64'h0);
      sawDone = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
      end
      checkOutput("abort.noDone", {63'b0, sawDone}, 64'd0);
      checkOutput("abort.ansHeld", div_ans, 64'h0);
      prevAns = 64'h0;
      runOp("afterAbort", 32'd1000, 32'd33, 1'b0, 64'h0000001E_0000000A, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
